// File: rtl/servo_spi_commander.sv
// CPOL=1/CPHA=0 LSB-first SPI transmitter: one 3-byte servo frame (index, pulse hi, pulse lo) per command.
// Optional build macro SERVO_PULSE_CLAMP_EN clamps the latched pulse to [PULSE_MIN, PULSE_MAX].
module servo_spi_commander #(
  parameter int CLKS_PER_HALF_BIT = 8,
  parameter int GAP_CLKS          = 16,
  parameter int PULSE_MIN         = 500,
  parameter int PULSE_MAX         = 2500
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [7:0]  i_index,
  input  logic [15:0] i_pulse,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_spi_clock,
  output logic        o_mosi,
  output logic        o_select
);

`ifdef SERVO_PULSE_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [7:0]  HALF_LAST = 8'(CLKS_PER_HALF_BIT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CLKS - 2);
  localparam logic [15:0] PMIN      = 16'(PULSE_MIN);
  localparam logic [15:0] PMAX      = 16'(PULSE_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t      state;
  logic [23:0] shreg;
  logic [4:0]  bit_cnt;
  logic [7:0]  div;
  logic [15:0] gap_cnt;
  logic [15:0] pulse_eff;
  logic        half_done;

  always_comb begin
    pulse_eff = i_pulse;
    if (CLAMP_EN && (i_pulse < PMIN))      pulse_eff = PMIN;
    else if (CLAMP_EN && (i_pulse > PMAX)) pulse_eff = PMAX;
  end

  assign half_done = (div == HALF_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      div         <= '0;
      gap_cnt     <= '0;
      o_ready     <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_spi_clock <= 1'b1;
      o_mosi      <= 1'b0;
      o_select    <= 1'b1;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            // Frame is {pulse lo, pulse hi, index} so a right shift walks index bit 0 out first.
            shreg    <= {1'b0, pulse_eff[7:0], pulse_eff[15:8], i_index[7:1]};
            o_mosi   <= i_index[0];
            o_select <= 1'b0;
            o_ready  <= 1'b0;
            o_busy   <= 1'b1;
            div      <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_done) begin
            div <= '0;
            if (o_spi_clock) begin
              o_spi_clock <= 1'b0;
            end else begin
              o_spi_clock <= 1'b1;
              if (bit_cnt == 5'd23) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                o_mosi  <= shreg[0];
                shreg   <= {1'b0, shreg[23:1]};
              end
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        HOLD: begin
          if (half_done) begin
            div      <= '0;
            o_select <= 1'b1;
            o_mosi   <= 1'b0;
            o_done   <= 1'b1;
            if (GAP_CLKS == 1) begin
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
              state   <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        GAP: begin
          // Ready rises one clock early so the next command lands exactly GAP_CLKS after select release.
          if (gap_cnt == GAP_LAST) begin
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_spi_commander.sv
// Bench for servo_spi_commander: two instances (H=8/GAP=16 and H=2/GAP=4), a wire monitor that
// rebuilds frames from SCLK falling edges, a vector table, corner sequences and random commands.
module tb_servo_spi_commander;
  localparam int H0 = 8, G0 = 16, H1 = 2, G1 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid [2];
  logic [7:0]  idx   [2];
  logic [15:0] pulse [2];
  logic ready [2], busy [2], done [2], sclk [2], mosi [2], sel [2];

  always #5 clk = ~clk;

  servo_spi_commander #(.CLKS_PER_HALF_BIT(H0), .GAP_CLKS(G0)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid[0]), .i_index(idx[0]), .i_pulse(pulse[0]),
    .o_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]), .o_spi_clock(sclk[0]),
    .o_mosi(mosi[0]), .o_select(sel[0]));

  servo_spi_commander #(.CLKS_PER_HALF_BIT(H1), .GAP_CLKS(G1)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid[1]), .i_index(idx[1]), .i_pulse(pulse[1]),
    .o_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]), .o_spi_clock(sclk[1]),
    .o_mosi(mosi[1]), .o_select(sel[1]));

  typedef struct {
    int              nbits;
    logic [2:0][7:0] by;
    int              start;
    int              stop;
    int              bad_timing;
    int              glitch;
    logic            done_at_end;
  } frame_t;

  typedef struct {
    int          d;
    logic [7:0]  i;
    logic [15:0] p;
    logic [23:0] exp;
  } vec_t;

  int     cyc = 0;
  frame_t flog [2][64];
  frame_t cur  [2];
  int     fcnt [2] = '{0, 0};
  int     dcnt [2] = '{0, 0};
  int     last_fall [2] = '{0, 0};
  logic   p_sclk [2] = '{1'b1, 1'b1};
  logic   p_sel  [2] = '{1'b1, 1'b1};
  logic   p_mosi [2] = '{1'b0, 1'b0};
  logic   p_done [2] = '{1'b0, 1'b0};
  int     done_long = 0;
  int     busy_bad = 0;
  int     n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Wire monitor: one frame per select-low window, bits taken on SCLK falling edges.
  always @(negedge clk) begin
    int h;
    for (int d = 0; d < 2; d++) begin
      h = (d == 0) ? H0 : H1;
      if (p_sel[d] && !sel[d]) begin
        cur[d].nbits = 0; cur[d].by = '0; cur[d].start = cyc; cur[d].stop = 0;
        cur[d].bad_timing = 0; cur[d].glitch = 0; cur[d].done_at_end = 1'b0;
      end
      if (!sel[d] && p_sclk[d] && !sclk[d]) begin
        if (cur[d].nbits == 0) begin
          if (cyc - cur[d].start != h) cur[d].bad_timing++;
        end else if (cyc - last_fall[d] != 2 * h) cur[d].bad_timing++;
        if (cur[d].nbits < 24) cur[d].by[cur[d].nbits / 8][cur[d].nbits % 8] = mosi[d];
        cur[d].nbits++;
        last_fall[d] = cyc;
      end
      if (!sel[d] && !p_sel[d] && !sclk[d] && !p_sclk[d] && (mosi[d] != p_mosi[d])) cur[d].glitch++;
      if (!p_sel[d] && sel[d]) begin
        cur[d].stop = cyc;
        cur[d].done_at_end = done[d];
        if (cur[d].nbits > 0 && (cyc - last_fall[d] != 2 * h)) cur[d].bad_timing++;
        if (fcnt[d] < 64) flog[d][fcnt[d]] = cur[d];
        fcnt[d]++;
      end
      if (!p_done[d] && done[d]) dcnt[d]++;
      if (p_done[d] && done[d]) done_long++;
      if (busy[d] == ready[d]) busy_bad++;
      p_sclk[d] = sclk[d]; p_sel[d] = sel[d]; p_mosi[d] = mosi[d]; p_done[d] = done[d];
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Reference: the wire carries index, then the (optionally clamped) pulse high byte, then low byte.
  function automatic logic [23:0] model(input logic [7:0] i, input logic [15:0] p);
    int q;
    q = p;
`ifdef SERVO_PULSE_CLAMP_EN
    if (q < 500)  q = 500;
    if (q > 2500) q = 2500;
`endif
    return {i, 16'(q)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (!ready[d] && n < 2000) begin tick(); n++; end
    if (!ready[d]) chk("ready_timeout", ready[d], 1);
  endtask

  task automatic launch(input int d, input logic [7:0] i, input logic [15:0] p, output int t);
    wait_ready(d);
    valid[d] = 1'b1; idx[d] = i; pulse[d] = p;
    tick();
    t = cyc;
    valid[d] = 1'b0;
  endtask

  task automatic wait_frame(input int d, input int base);
    int n;
    n = 0;
    while (fcnt[d] <= base && n < 3000) begin tick(); n++; end
    if (fcnt[d] <= base) chk("frame_timeout", fcnt[d], base + 1);
  endtask

  task automatic check_frame(input string tag, input int d, input int k, input int t,
                             input logic [23:0] exp);
    frame_t f;
    int h;
    h = (d == 0) ? H0 : H1;
    f = flog[d][k];
    chk({tag, "_falls"}, f.nbits, 24);
    chk({tag, "_bytes"}, {f.by[0], f.by[1], f.by[2]}, exp);
    chk({tag, "_start"}, f.start, t);
    chk({tag, "_len"}, f.stop - t, 49 * h);
    chk({tag, "_done"}, f.done_at_end, 1);
    chk({tag, "_timing"}, f.bad_timing, 0);
    chk({tag, "_mosi_stable"}, f.glitch, 0);
  endtask

  vec_t vt [6];

  initial begin
    int t, t1, t2, base, dbase, n, d;
    logic [7:0]  ri;
    logic [15:0] rp;

    vt[0] = '{0, 8'h01, 16'd1500, 24'h0105DC};
    vt[1] = '{0, 8'h00, 16'd1000, 24'h0003E8};
    vt[2] = '{0, 8'hFE, 16'd2000, 24'hFE07D0};
`ifdef SERVO_PULSE_CLAMP_EN
    vt[3] = '{0, 8'h10, 16'd100,  24'h1001F4};
    vt[4] = '{0, 8'h11, 16'd3000, 24'h1109C4};
    vt[5] = '{1, 8'hA5, 16'hFFFF, 24'hA509C4};
`else
    vt[3] = '{0, 8'h10, 16'd100,  24'h100064};
    vt[4] = '{0, 8'h11, 16'd3000, 24'h110BB8};
    vt[5] = '{1, 8'hA5, 16'hFFFF, 24'hA5FFFF};
`endif

    for (int k = 0; k < 2; k++) begin valid[k] = 1'b0; idx[k] = '0; pulse[k] = '0; end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_sclk", sclk[k], 1);
      chk("rst_select", sel[k], 1);
      chk("rst_mosi", mosi[k], 0);
      chk("rst_ready", ready[k], 1);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < 6; k++) begin
      base = fcnt[vt[k].d];
      launch(vt[k].d, vt[k].i, vt[k].p, t);
      wait_frame(vt[k].d, base);
      check_frame("vec", vt[k].d, base, t, vt[k].exp);
    end

    // Back-to-back with valid held high.
    wait_ready(0);
    base = fcnt[0]; dbase = dcnt[0];
    valid[0] = 1'b1; idx[0] = 8'd0; pulse[0] = 16'd1000;
    n = 0;
    do begin tick(); n++; end while (ready[0] && n < 100);
    t1 = cyc;
    idx[0] = 8'd1; pulse[0] = 16'd2000;
    n = 0;
    while (!ready[0] && n < 2000) begin tick(); n++; end
    tick();
    t2 = cyc;
    valid[0] = 1'b0;
    chk("b2b_accept_gap", t2 - t1, 49 * H0 + G0);
    wait_frame(0, base + 1);
    check_frame("b2b0", 0, base, t1, model(8'd0, 16'd1000));
    check_frame("b2b1", 0, base + 1, t2, model(8'd1, 16'd2000));
    chk("b2b_done_pulses", dcnt[0] - dbase, 2);

    // A command offered mid-frame is dropped.
    base = fcnt[0];
    launch(0, 8'h02, 16'h1234, t);
    repeat (99) tick();
    valid[0] = 1'b1; idx[0] = 8'h07; pulse[0] = 16'h0100;
    tick();
    valid[0] = 1'b0;
    wait_frame(0, base);
    check_frame("busy", 0, base, t, model(8'h02, 16'h1234));
    repeat (450) tick();
    chk("busy_no_extra_frame", fcnt[0], base + 1);

    // Asynchronous reset mid-frame, then a clean frame.
    launch(0, 8'h33, 16'd1800, t);
    repeat (149) tick();
    chk("mid_frame_select", sel[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_select", sel[0], 1);
    chk("arst_sclk", sclk[0], 1);
    chk("arst_mosi", mosi[0], 0);
    chk("arst_ready", ready[0], 1);
    chk("arst_busy", busy[0], 0);
    tick();
    rst_n = 1'b1;
    tick();
    base = fcnt[0];
    launch(0, 8'h44, 16'd1200, t);
    wait_frame(0, base);
    check_frame("post_rst", 0, base, t, model(8'h44, 16'd1200));

    // Random commands, pulses biased toward the clamp boundaries.
    for (int k = 0; k < 16; k++) begin
      d  = int'($urandom_range(1, 0));
      ri = 8'($urandom);
      case ($urandom_range(3, 0))
        0:       rp = 16'($urandom_range(499, 0));
        1:       rp = 16'($urandom_range(65535, 2501));
        2:       rp = ($urandom_range(1, 0) == 0) ? 16'(499 + $urandom_range(2, 0))
                                                  : 16'(2499 + $urandom_range(2, 0));
        default: rp = 16'($urandom_range(2500, 500));
      endcase
      base = fcnt[d];
      launch(d, ri, rp, t);
      wait_frame(d, base);
      check_frame("rand", d, base, t, model(ri, rp));
    end

    chk("done_one_cycle", done_long, 0);
    chk("busy_is_not_ready", busy_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
